// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between the pipeline (P) and the multi-cycle unit (M)
//
// P has fixed priority. M is forced through after STARVE_MAX consecutive blocked cycles.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_p_valid/i_p_addr/i_p_data    pipeline writeback request
//   o_p_ready                      pipeline request accepted this cycle (combinational)
//   i_m_valid/i_m_addr/i_m_data    multi-cycle unit write request
//   o_m_ready                      multi-cycle request accepted this cycle (combinational)
//   o_we3/o_a3/o_wd3               registered register-file write port
//   o_m_forced                     high while M is being forced through
module regfile_wr_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_p_valid,
    input  logic [ADDR_W-1:0] i_p_addr,
    input  logic [DATA_W-1:0] i_p_data,
    output logic              o_p_ready,
    input  logic              i_m_valid,
    input  logic [ADDR_W-1:0] i_m_addr,
    input  logic [DATA_W-1:0] i_m_data,
    output logic              o_m_ready,
    output logic              o_we3,
    output logic [ADDR_W-1:0] o_a3,
    output logic [DATA_W-1:0] o_wd3,
    output logic              o_m_forced
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);
    logic [CW-1:0]     r_cnt;
    logic              w_force;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    assign w_force    = r_cnt == MAX;
    assign o_p_ready  = i_p_valid && !w_force;
    assign o_m_ready  = i_m_valid && (w_force || !i_p_valid);
    assign o_m_forced = w_force;
    assign w_addr     = o_m_ready ? i_m_addr : i_p_addr;
    assign w_data     = o_m_ready ? i_m_data : i_p_data;
    // Grants to register 0 are accepted but never reach the write port.
    assign w_we       = (o_p_ready || o_m_ready) && (w_addr != '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            o_we3 <= 1'b0;
            o_a3  <= '0;
            o_wd3 <= '0;
        end else begin
            r_cnt <= (i_m_valid && !o_m_ready) ? (w_force ? r_cnt : r_cnt + 1'b1) : '0;
            o_we3 <= w_we;
            if (w_we) begin
                o_a3  <= w_addr;
                o_wd3 <= w_data;
            end
        end
    end
endmodule
